// File: rtl/quanet_prbs_pkg.sv
// Purpose: shared PRBS31 constants, checker state encoding and counter widths.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package quanet_prbs_pkg;

    localparam int DATA_W     = 32;
    localparam int PRBS_TAP_A = 31;          // b[n] = b[n-31] ^ b[n-28]
    localparam int PRBS_TAP_B = 28;
    localparam int HIST_W     = PRBS_TAP_A;  // deepest lag reached from the current word
    localparam int NERR_W     = 6;           // popcount of a 32-bit word, 0..32
    localparam int ERR_CNT_W  = 32;
    localparam int WORD_CNT_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    // Self-synchronous check: the expected bit comes from the received stream
    // itself. hist holds the newest HIST_W bits of the previous word (its bit 0
    // can never be reached by a 31-bit lag from a 32-bit word, so it is not kept).
    // Stream index HIST_W+i is data[i]; a lag of L maps to index HIST_W+i-L.
    function automatic logic [DATA_W-1:0] prbs31_mismatch(
        input logic [HIST_W-1:0] hist,
        input logic [DATA_W-1:0] data
    );
        logic [DATA_W+HIST_W-1:0] s;
        logic [DATA_W-1:0]        mis;
        s = {data, hist};
        for (int i = 0; i < DATA_W; i++) begin
            mis[i] = s[HIST_W+i] ^ s[HIST_W+i-PRBS_TAP_A] ^ s[HIST_W+i-PRBS_TAP_B];
        end
        return mis;
    endfunction

endpackage

// File: rtl/prbs_popcnt32.sv
// Purpose: combinational 32->6 population count (adder tree), registered by the parent.
// Latency: 0 clocks (pure combinational).
// Backpressure: none.
// Ports: vec_i - 32-bit input vector; cnt_o - number of set bits, 0..32.
module prbs_popcnt32 (
    input  logic [31:0] vec_i,
    output logic [5:0]  cnt_o
);

    logic [1:0] l1 [16];
    logic [2:0] l2 [8];
    logic [3:0] l3 [4];
    logic [4:0] l4 [2];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            l1[i] = {1'b0, vec_i[2*i]} + {1'b0, vec_i[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
        end
        cnt_o = {1'b0, l4[0]} + {1'b0, l4[1]};
    end

endmodule

// File: rtl/gth_rx_prbs_check.sv
// Purpose: self-synchronous PRBS31 receive checker with lock FSM and saturating error/word counters.
// Latency: 3 clocks from rx_data to err_pulse / counters / locked (S0 input, S1 mismatch, S2 popcount+state).
// Backpressure: none; accepts one word per clock, rx_vld low simply forces re-acquisition.
// Ports: clk/rstn - RX user clock, async active-low reset; rx_vld/rx_data - received word (bit 0 earliest);
//        clr_cnt - zeroes counters and lock_lost; locked, err_pulse, err_cnt, word_cnt, lock_lost - status.
module gth_rx_prbs_check
    import quanet_prbs_pkg::*;
#(
    parameter int unsigned LOCK_WORDS = 64,
    parameter int unsigned LOSS_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_vld,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  clr_cnt,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WORD_CNT_W-1:0] word_cnt,
    output logic                  lock_lost
);

    localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int BAD_W  = $clog2(LOSS_WORDS + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WORDS - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_WORDS - 1);

    // S0: input capture
    logic              s0_vld_q;
    logic [DATA_W-1:0] s0_data_q;

    // S1: history and mismatch
    logic [HIST_W-1:0] hist_q;
    logic              prime_q;   // history holds a valid previous word
    logic              s1_vld_q;
    logic              s1_chk_q;  // valid word that was actually checked
    logic              s1_zero_q;
    logic [DATA_W-1:0] s1_mis_q;

    // S2: state and counters
    prbs_state_t           state_q;
    logic [GOOD_W-1:0]     good_q;
    logic [BAD_W-1:0]      bad_q;
    logic                  locked_q;
    logic                  err_pulse_q;
    logic                  lock_lost_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [WORD_CNT_W-1:0] word_cnt_q;

    logic [NERR_W-1:0]     nerr;
    logic                  word_bad;
    logic                  cnt_en;
    logic                  lost_set;
    logic [NERR_W-1:0]     err_inc;
    logic [ERR_CNT_W:0]    err_sum;
    logic [WORD_CNT_W:0]   word_sum;
    logic [ERR_CNT_W-1:0]  err_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_d;
    logic                  lock_lost_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_vld_q  <= 1'b0;
            s0_data_q <= '0;
        end else begin
            s0_vld_q  <= rx_vld;
            s0_data_q <= rx_data;
        end
    end

    // A gap in rx_vld invalidates the history, so the next valid word only primes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q    <= '0;
            prime_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_chk_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mis_q  <= '0;
        end else begin
            s1_vld_q  <= s0_vld_q;
            s1_chk_q  <= s0_vld_q & prime_q;
            s1_zero_q <= (s0_data_q == '0);
            s1_mis_q  <= prbs31_mismatch(hist_q, s0_data_q);
            prime_q   <= s0_vld_q;
            if (s0_vld_q) begin
                hist_q <= s0_data_q[DATA_W-1:DATA_W-HIST_W];
            end
        end
    end

    prbs_popcnt32 u_popcnt (
        .vec_i (s1_mis_q),
        .cnt_o (nerr)
    );

    // All-zero data satisfies the recurrence, so it is treated as errored.
    assign word_bad = (nerr != '0) || s1_zero_q;
    assign cnt_en   = (state_q == ST_LOCKED) && s1_vld_q && s1_chk_q;
    assign lost_set = (state_q == ST_LOCKED) &&
                      (!s1_vld_q || (s1_chk_q && word_bad && (bad_q == BAD_LAST)));

    // Saturating adds: one extra carry bit detects overflow. clr_cnt beats any increment.
    always_comb begin
        err_inc    = s1_zero_q ? NERR_W'(DATA_W) : nerr;
        err_sum    = {1'b0, err_cnt_q} + {{(ERR_CNT_W+1-NERR_W){1'b0}}, err_inc};
        word_sum   = {1'b0, word_cnt_q} + (WORD_CNT_W+1)'(1);
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        if (cnt_en) begin
            err_cnt_d  = err_sum[ERR_CNT_W]   ? '1 : err_sum[ERR_CNT_W-1:0];
            word_cnt_d = word_sum[WORD_CNT_W] ? '1 : word_sum[WORD_CNT_W-1:0];
        end
        if (clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
        // A loss event coinciding with a clear is kept, so it is never silently missed.
        lock_lost_d = lost_set ? 1'b1 : (clr_cnt ? 1'b0 : lock_lost_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            lock_lost_q <= lock_lost_d;
            err_pulse_q <= 1'b0;
            if (!s1_vld_q) begin
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
                good_q   <= '0;
                bad_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SEARCH;
                        good_q  <= '0;
                        bad_q   <= '0;
                    end
                    ST_SEARCH: begin
                        if (s1_chk_q) begin
                            if (word_bad) begin
                                good_q <= '0;
                            end else if (good_q == GOOD_LAST) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                good_q   <= '0;
                                bad_q    <= '0;
                            end else begin
                                good_q <= good_q + GOOD_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (word_bad) begin
                            err_pulse_q <= 1'b1;
                            if (bad_q == BAD_LAST) begin
                                state_q  <= ST_SEARCH;
                                locked_q <= 1'b0;
                                bad_q    <= '0;
                                good_q   <= '0;
                            end else begin
                                bad_q <= bad_q + BAD_W'(1);
                            end
                        end else begin
                            bad_q <= '0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_gth_rx_prbs_check.sv
// Purpose: directed, table-driven bench for gth_rx_prbs_check plus hand sequences for corner cases.
// Latency: outputs after a word's step reflect the word presented two steps earlier.
// Backpressure: none.
module tb_gth_rx_prbs_check;

    localparam int K_PRBS = 0;
    localparam int K_ZERO = 1;
    localparam int K_FLIP = 2;
    localparam int NV     = 17;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx_vld;
    logic [31:0] rx_data;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [47:0] word_cnt;
    logic        lock_lost;

    int n_cmp = 0;
    int n_bad = 0;

    // PRBS31 source: g[0] is b[n-31], g[30] is b[n-1].
    logic [30:0] g = 31'h1234_5678;

    always #5 clk = ~clk;

    gth_rx_prbs_check #(
        .LOCK_WORDS (64),
        .LOSS_WORDS (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt),
        .lock_lost (lock_lost)
    );

    typedef struct {
        logic        vld;
        int          kind;
        logic        clr;
        int          n;
        logic        e_lock;
        logic        e_pulse;
        logic [31:0] e_err;
        logic [47:0] e_word;
        logic        e_lost;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_lock, input logic e_pulse,
                              input logic [31:0] e_err, input logic [47:0] e_word, input logic e_lost);
        check($sformatf("%s.locked", tag),    {63'd0, locked},    {63'd0, e_lock});
        check($sformatf("%s.err_pulse", tag), {63'd0, err_pulse}, {63'd0, e_pulse});
        check($sformatf("%s.err_cnt", tag),   {32'd0, err_cnt},   {32'd0, e_err});
        check($sformatf("%s.word_cnt", tag),  {16'd0, word_cnt},  {16'd0, e_word});
        check($sformatf("%s.lock_lost", tag), {63'd0, lock_lost}, {63'd0, e_lost});
    endtask

    task automatic prbs_word(output logic [31:0] w);
        logic nb;
        for (int i = 0; i < 32; i++) begin
            nb   = g[0] ^ g[3];
            w[i] = nb;
            g    = {nb, g[30:1]};
        end
    endtask

    task automatic step(input logic vld, input logic [31:0] d, input logic clr);
        rx_vld  = vld;
        rx_data = d;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic send(input int kind, input int n, input logic vld, input logic clr);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            if (!vld) begin
                d = 32'hDEAD_BEEF;
            end else if (kind == K_ZERO) begin
                d = '0;
            end else begin
                prbs_word(d);
                if (kind == K_FLIP) d[0] = ~d[0];
            end
            step(vld, d, clr);
        end
    endtask

    initial begin
        // Word numbering in comments: k-th valid-or-invalid word presented after reset.
        vecs[0]  = '{1'b0, K_PRBS, 1'b0,  3, 1'b0, 1'b0, 32'd0,   48'd0,  1'b0}; // idle after reset
        vecs[1]  = '{1'b1, K_PRBS, 1'b0, 66, 1'b0, 1'b0, 32'd0,   48'd0,  1'b0}; // 63 checked so far
        vecs[2]  = '{1'b1, K_PRBS, 1'b0,  1, 1'b1, 1'b0, 32'd0,   48'd0,  1'b0}; // 64th clean -> lock
        vecs[3]  = '{1'b1, K_PRBS, 1'b0, 10, 1'b1, 1'b0, 32'd0,   48'd10, 1'b0};
        vecs[4]  = '{1'b1, K_FLIP, 1'b0,  1, 1'b1, 1'b0, 32'd0,   48'd11, 1'b0}; // bit 0 flipped
        vecs[5]  = '{1'b1, K_PRBS, 1'b0,  2, 1'b1, 1'b1, 32'd3,   48'd13, 1'b0}; // flip seen: 3 errors
        vecs[6]  = '{1'b1, K_PRBS, 1'b0,  1, 1'b1, 1'b0, 32'd3,   48'd14, 1'b0}; // single pulse only
        vecs[7]  = '{1'b0, K_PRBS, 1'b0,  1, 1'b1, 1'b0, 32'd3,   48'd15, 1'b0}; // vld drop enters pipe
        vecs[8]  = '{1'b1, K_PRBS, 1'b0,  2, 1'b0, 1'b0, 32'd3,   48'd16, 1'b1}; // in-flight word counted
        vecs[9]  = '{1'b1, K_PRBS, 1'b0, 64, 1'b0, 1'b0, 32'd3,   48'd16, 1'b1}; // 63 checked again
        vecs[10] = '{1'b1, K_PRBS, 1'b0,  1, 1'b1, 1'b0, 32'd3,   48'd16, 1'b1}; // relock
        vecs[11] = '{1'b1, K_PRBS, 1'b0,  3, 1'b1, 1'b0, 32'd3,   48'd19, 1'b1};
        vecs[12] = '{1'b1, K_ZERO, 1'b0,  4, 1'b1, 1'b1, 32'd67,  48'd23, 1'b1}; // 2 zero words seen
        vecs[13] = '{1'b1, K_ZERO, 1'b0,  2, 1'b0, 1'b1, 32'd131, 48'd25, 1'b1}; // 4th zero drops lock
        vecs[14] = '{1'b1, K_ZERO, 1'b0, 70, 1'b0, 1'b0, 32'd131, 48'd25, 1'b1}; // zeros never lock
        vecs[15] = '{1'b0, K_PRBS, 1'b1,  1, 1'b0, 1'b0, 32'd0,   48'd0,  1'b0}; // clr_cnt
        vecs[16] = '{1'b0, K_PRBS, 1'b0,  3, 1'b0, 1'b0, 32'd0,   48'd0,  1'b0};

        rstn    = 1'b0;
        rx_vld  = 1'b0;
        rx_data = '0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            send(vecs[v].kind, vecs[v].n, vecs[v].vld, vecs[v].clr);
            check_outs($sformatf("vec%0d", v), vecs[v].e_lock, vecs[v].e_pulse,
                       vecs[v].e_err, vecs[v].e_word, vecs[v].e_lost);
        end

        // Relock from IDLE, then saturate err_cnt with a 32-error word.
        send(K_PRBS, 66, 1'b1, 1'b0);
        check("relock.pre", {63'd0, locked}, 64'd0);
        send(K_PRBS, 1, 1'b1, 1'b0);
        check("relock.locked", {63'd0, locked}, 64'd1);
        send(K_PRBS, 3, 1'b1, 1'b0);
        check("relock.word_cnt", {16'd0, word_cnt}, 64'd3);
        send(K_ZERO, 1, 1'b1, 1'b0);
        send(K_PRBS, 1, 1'b1, 1'b0);
        force dut.err_cnt_q = 32'hFFFF_FFF0;
        #1;
        release dut.err_cnt_q;
        send(K_PRBS, 1, 1'b1, 1'b0);
        check("sat.err_cnt", {32'd0, err_cnt}, 64'hFFFF_FFFF);
        send(K_PRBS, 4, 1'b1, 1'b0);
        check("sat.hold", {32'd0, err_cnt}, 64'hFFFF_FFFF);
        check("sat.locked", {63'd0, locked}, 64'd1);

        // clr_cnt on the same edge as an errored word's increment.
        send(K_ZERO, 1, 1'b1, 1'b0);
        send(K_PRBS, 1, 1'b1, 1'b0);
        send(K_PRBS, 1, 1'b1, 1'b1);
        check("clr.err_cnt", {32'd0, err_cnt}, 64'd0);
        check("clr.word_cnt", {16'd0, word_cnt}, 64'd0);
        check("clr.err_pulse", {63'd0, err_pulse}, 64'd1);
        send(K_PRBS, 1, 1'b1, 1'b0);
        check("clr.resume", {16'd0, word_cnt}, 64'd1);

        // Asynchronous reset between edges while locked.
        send(K_PRBS, 3, 1'b1, 1'b0);
        check("arst.pre_locked", {63'd0, locked}, 64'd1);
        #3 rstn = 1'b0;
        #1;
        check_outs("arst", 1'b0, 1'b0, 32'd0, 48'd0, 1'b0);
        rx_vld = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
        send(K_PRBS, 66, 1'b1, 1'b0);
        check("arst.relock_pre", {63'd0, locked}, 64'd0);
        send(K_PRBS, 1, 1'b1, 1'b0);
        check("arst.relock", {63'd0, locked}, 64'd1);
        send(K_PRBS, 3, 1'b1, 1'b0);
        check_outs("arst.run", 1'b1, 1'b0, 32'd0, 48'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
